pid_pwm_out: RTL and testbench

//  Downstream stage of the PID controller: converts per-channel signed motor power (m_k, ow bits)

---
 rtl/pid_pwm_pkg.sv | 30 +++
 rtl/pid_pwm_out_if.sv | 18 +
 rtl/pid_pwm_out_channel.sv | 116 +++++++++++
 rtl/pid_pwm_out.sv | 77 +++++++
 tb/tb_pid_pwm_out.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pid_pwm_pkg.sv
// Shared types and helpers for the PID PWM output stage.
// Optional feature macro: PID_PWM_DEADTIME_EN (channel deadtime FSM).
package pid_pwm_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DEAD = 1'b1
   } ch_state_t;

   // Magnitude width derived from the signed power width.
   function automatic int pwm_mw(input int ow);
      return ow - 1;
   endfunction

   // |v| for a sign-extended ow-bit value; the most negative code clamps to
   // the largest positive magnitude so the result never wraps.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] i_v, input int ow);
      logic signed [31:0] w_min;
      logic [31:0]        w_max;
      w_min = -(32'sd1 <<< (ow - 1));
      w_max = (32'd1 << (ow - 1)) - 32'd1;
      if (i_v == w_min)
         return w_max;
      else if (i_v < 0)
         return 32'(-i_v);
      else
         return 32'(i_v);
   endfunction

endpackage

// File: rtl/pid_pwm_out_if.sv
// Bus between the PID core (master) and the PWM output stage (slave).
// Optional feature macro: PID_PWM_DEADTIME_EN (no effect on this interface).
interface pid_pwm_out_if #(
   parameter int aw = 1,
   parameter int ow = 12
);
   localparam int an = 2 ** aw;

   logic [aw-1:0]        a;
   logic signed [ow-1:0] m_k;
   logic                 load;
   logic [an-1:0]        pwm;
   logic [an-1:0]        dir;
   logic                 period;

   modport master (output a, m_k, load, input pwm, dir, period);
   modport slave  (input a, m_k, load, output pwm, dir, period);
endinterface

// File: rtl/pid_pwm_out_channel.sv
// One PWM channel: shadow/active duty, compare against the shared counter,
// and (with PID_PWM_DEADTIME_EN) a deadtime FSM on direction reversal.
module pid_pwm_channel
   import pid_pwm_pkg::*;
#(
   parameter  int ow       = 12,
   parameter  int deadtime = 16,
   localparam int mw       = pwm_mw(ow)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic signed [ow-1:0] i_m_k,
   input  logic                 i_boundary,
   input  logic [mw-1:0]        i_cnt,
   output logic                 o_pwm,
   output logic                 o_dir
);

   logic [mw-1:0] w_mag_in, w_nxt_mag, r_sh_mag, r_act_mag;
   logic          w_dir_in, w_nxt_dir, r_sh_dir, r_act_dir;
   logic          w_run, r_pwm, r_dir;

   assign w_mag_in  = mw'(sat_abs(32'(i_m_k), ow));
   assign w_dir_in  = i_m_k[ow-1];
   // A load on the boundary clock goes straight to the active register.
   assign w_nxt_mag = i_load ? w_mag_in : r_sh_mag;
   assign w_nxt_dir = i_load ? w_dir_in : r_sh_dir;

   // Shadow duty: last captured value wins until the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_mag <= '0;
         r_sh_dir <= 1'b0;
      end else if (i_load) begin
         r_sh_mag <= w_mag_in;
         r_sh_dir <= w_dir_in;
      end
   end

   // Active duty changes only at period boundaries, keeping pulses glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_mag <= '0;
         r_act_dir <= 1'b0;
      end else if (i_boundary) begin
         r_act_mag <= w_nxt_mag;
         r_act_dir <= w_nxt_dir;
      end
   end

`ifdef PID_PWM_DEADTIME_EN
   localparam int DW = (deadtime > 0) ? $clog2(deadtime + 1) : 1;

   ch_state_t     r_state, w_state_nxt;
   logic [DW-1:0] r_dead, w_dead_nxt;
   logic          w_rev;

   assign w_rev = i_boundary && (w_nxt_dir != r_act_dir) && (w_nxt_mag != '0) && (deadtime > 0);

   // Deadtime FSM state and down-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_dead  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dead  <= w_dead_nxt;
      end
   end

   // Enter/extend DEAD on a reversal; leave after deadtime clocks.
   always_comb begin
      w_state_nxt = r_state;
      w_dead_nxt  = r_dead;
      case (r_state)
         ST_RUN: begin
            if (w_rev) begin
               w_state_nxt = ST_DEAD;
               w_dead_nxt  = DW'(deadtime - 1);
            end
         end
         ST_DEAD: begin
            if (w_rev)
               w_dead_nxt = DW'(deadtime - 1);
            else if (r_dead == '0)
               w_state_nxt = ST_RUN;
            else
               w_dead_nxt = r_dead - DW'(1);
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_run = (r_state == ST_RUN);
`else
   logic w_unused_dt;
   assign w_unused_dt = (deadtime > 0);
   assign w_run       = 1'b1;
`endif

   // Registered compare: one clock behind the shared counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= 1'b0;
         r_dir <= 1'b0;
      end else begin
         r_pwm <= w_run && (i_cnt < r_act_mag);
         r_dir <= r_act_dir;
      end
   end

   assign o_pwm = r_pwm;
   assign o_dir = r_dir;

endmodule

// File: rtl/pid_pwm_out.sv
// PID PWM output stage top: reset synchroniser, prescaler, shared period
// counter, load address decode and one pid_pwm_channel per address.
// Optional feature macro: PID_PWM_DEADTIME_EN (enables channel deadtime).
module pid_pwm_out
   import pid_pwm_pkg::*;
#(
   parameter int aw       = 1,
   parameter int ow       = 12,
   parameter int prescale = 0,
   parameter int deadtime = 16
) (
   input logic          clk,
   input logic          reset_n,
   pid_pwm_out_if.slave bus
);

   localparam int an = 2 ** aw;
   localparam int mw = pwm_mw(ow);
   localparam int PW = (prescale > 0) ? $clog2(prescale + 1) : 1;

   logic [1:0]    r_rst_sync;
   logic          w_rst_n;
   logic [PW-1:0] r_pre;
   logic [mw-1:0] r_cnt;
   logic          r_period;
   logic          w_tick, w_boundary;
   logic [an-1:0] w_pwm, w_dir;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n    = r_rst_sync[1];
   assign w_tick     = (r_pre == PW'(prescale));
   assign w_boundary = w_tick && (r_cnt == {mw{1'b1}});

   // Prescaler: one counter tick every prescale+1 clocks.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)    r_pre <= '0;
      else if (w_tick) r_pre <= '0;
      else             r_pre <= r_pre + PW'(1);
   end

   // Shared period counter (wraps naturally) and boundary pulse.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cnt    <= '0;
         r_period <= 1'b0;
      end else begin
         if (w_tick) r_cnt <= r_cnt + mw'(1);
         r_period <= w_boundary;
      end
   end

   for (genvar g = 0; g < an; g++) begin : g_ch
      pid_pwm_channel #(
         .ow       (ow),
         .deadtime (deadtime)
      ) u_ch (
         .clk        (clk),
         .rst_n      (w_rst_n),
         .i_load     (bus.load && (bus.a == aw'(g))),
         .i_m_k      (bus.m_k),
         .i_boundary (w_boundary),
         .i_cnt      (r_cnt),
         .o_pwm      (w_pwm[g]),
         .o_dir      (w_dir[g])
      );
   end

   assign bus.pwm    = w_pwm;
   assign bus.dir    = w_dir;
   assign bus.period = r_period;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Bench for pid_pwm_out: per-period duty/direction/length checks against a
// behavioural model of shadow/active duty. Honours PID_PWM_DEADTIME_EN.
`timescale 1ns/1ps
module tb_pid_pwm_out;

   localparam int AW         = 1;
   localparam int OW         = 12;
   localparam int AN         = 2;
   localparam int PERIOD_CLK = 2048;
   localparam int DEADT      = 16;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   pid_pwm_out_if #(.aw(AW), .ow(OW)) bus ();

   pid_pwm_out #(
      .aw       (AW),
      .ow       (OW),
      .prescale (0),
      .deadtime (DEADT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int            n_vec = 0;
   int            n_bad = 0;
   int            sh_mag  [AN];
   bit            sh_dir  [AN];
   int            act_mag [AN];
   bit            act_dir [AN];
   int            exp_hi  [AN];
   int            acc     [AN];
   int            len;
   bit            take_dir, seen;
   logic [AN-1:0] dir_rec;
`ifdef PID_PWM_DEADTIME_EN
   bit            rev;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_mag(input int v);
      if (v == -2048) return 2047;
      return (v < 0) ? -v : v;
   endfunction

   // Frame monitor: a frame runs from the sample after one period pulse up to
   // and including the next pulse sample.
   always @(negedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < AN; c++) begin
            sh_mag[c] = 0; sh_dir[c] = 0; act_mag[c] = 0; act_dir[c] = 0;
            exp_hi[c] = 0; acc[c] = 0;
         end
         len = 0; take_dir = 0; seen = 0; dir_rec = '0;
      end else begin
         len++;
         for (int c = 0; c < AN; c++) acc[c] += int'(bus.pwm[c]);
         if (take_dir) begin
            dir_rec  = bus.dir;
            take_dir = 0;
         end
         if (bus.period) begin
            if (seen) begin
               chk("period_len", len, PERIOD_CLK);
               for (int c = 0; c < AN; c++) begin
                  chk($sformatf("pwm_hi[%0d]", c), acc[c], exp_hi[c]);
                  chk($sformatf("dir[%0d]", c), dir_rec[c], act_dir[c]);
               end
            end
            for (int c = 0; c < AN; c++) begin
`ifdef PID_PWM_DEADTIME_EN
               rev = (sh_dir[c] != act_dir[c]) && (sh_mag[c] != 0);
`endif
               act_mag[c] = sh_mag[c];
               act_dir[c] = sh_dir[c];
               exp_hi[c]  = act_mag[c];
`ifdef PID_PWM_DEADTIME_EN
               if (rev) exp_hi[c] = (act_mag[c] > DEADT) ? act_mag[c] - DEADT : 0;
`endif
               acc[c] = 0;
            end
            seen = 1; len = 0; take_dir = 1;
         end
      end
   end

   task automatic do_load(input int ch, input int val);
      logic signed [OW-1:0] mv;
      mv = OW'(val);
      @(negedge clk);
      bus.a    = AW'(ch);
      bus.m_k  = mv;
      bus.load = 1'b1;
      @(posedge clk);
      if (reset_n) begin
         sh_mag[ch] = ref_mag(val);
         sh_dir[ch] = (val < 0);
      end
      #1 bus.load = 1'b0;
   endtask

   task automatic wait_pulse();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.period && k < 3000);
      if (!bus.period) chk("pulse_timeout", 0, 1);
   endtask

   initial begin
      bus.a    = '0;
      bus.m_k  = '0;
      bus.load = 1'b0;
      reset_n  = 1'b0;
      repeat (3) @(posedge clk);
      do_load(0, 777);
      #1;
      chk("rst_pwm", bus.pwm, 0);
      chk("rst_dir", bus.dir, 0);
      chk("rst_period", bus.period, 0);
      @(negedge clk);
      reset_n = 1'b1;

      wait_pulse();
      do_load(0, 512);
      do_load(1, -2048);
      wait_pulse();
      wait_pulse();

      repeat (500) @(posedge clk);
      do_load(0, 100);
      repeat (300) @(posedge clk);
      do_load(0, 300);
      wait_pulse();
      wait_pulse();

      repeat (PERIOD_CLK - 1) @(posedge clk);
      do_load(0, 50);
      wait_pulse();
      wait_pulse();

      do_load(1, 400);
      wait_pulse();
      wait_pulse();
      do_load(1, -400);
      wait_pulse();
      wait_pulse();

      for (int it = 0; it < 10; it++) begin
         int nl;
         nl = $urandom_range(0, 3);
         for (int j = 0; j < nl; j++) begin
            repeat ($urandom_range(1, 400)) @(posedge clk);
            do_load($urandom_range(0, AN - 1), int'($urandom_range(0, 4095)) - 2048);
         end
         wait_pulse();
      end
      wait_pulse();

      do_load(1, -2048);
      wait_pulse();
      wait_pulse();
      repeat (100) @(posedge clk);
      #2;
      chk("pre_rst_pwm1", bus.pwm[1], 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_pwm", bus.pwm, 0);
      chk("async_rst_dir", bus.dir, 0);
      chk("async_rst_period", bus.period, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wait_pulse();
      wait_pulse();
      do_load(0, 1000);
      wait_pulse();
      wait_pulse();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
